// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
// Module  : hazard_sb
// Brief   : Forwarding select, load/branch stalls and multi-cycle scoreboard
//           (RAW/WAW/structural stalls) with a saturating stall counter.
// Rev     : 1.0
// ============================================================================
module hazard_sb #(
   parameter int AW       = 5,
   parameter int MC_DEPTH = 2,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   // decode stage
   input  logic [AW-1:0] rs1_D,
   input  logic [AW-1:0] rs2_D,
   input  logic [AW-1:0] rd_D,
   input  logic          regwrite_D,
   input  logic          mc_op_D,
   input  logic          branch_D,
   // execute stage
   input  logic [AW-1:0] rs1_E,
   input  logic [AW-1:0] rs2_E,
   input  logic [AW-1:0] rd_E,
   input  logic          regwrite_E,
   input  logic          memtoreg_E,
   input  logic          mc_issue_E,
   // memory / writeback stages
   input  logic [AW-1:0] rd_M,
   input  logic [AW-1:0] rd_W,
   input  logic          regwrite_M,
   input  logic          memtoreg_M,
   input  logic          regwrite_W,
   // multi-cycle unit completion
   input  logic          mc_done,
   input  logic [AW-1:0] mc_rd,
   input  logic          stat_clr,
   // outputs
   output logic [1:0]    forwardA_E,
   output logic [1:0]    forwardB_E,
   output logic [1:0]    forwardA_D,
   output logic [1:0]    forwardB_D,
   output logic          stall_PC,
   output logic          stall_F_to_D,
   output logic          flush_D_to_E,
   output logic          mc_busy,
   output logic          mc_full,
   output logic [CW-1:0] stall_cnt
);

   localparam int              c_NREG    = 1 << AW;
   localparam int              c_KW      = $clog2(MC_DEPTH + 1);
   localparam logic [c_KW-1:0] c_DEPTH   = MC_DEPTH[c_KW-1:0];
   localparam logic [c_KW:0]   c_DEPTH_W = MC_DEPTH[c_KW:0];

   logic [c_NREG-1:0] r_busy;
   logic [c_NREG-1:0] w_busy_set;
   logic [c_NREG-1:0] w_busy_clr;
   logic [c_NREG-1:0] w_busy_nxt;
   logic [c_KW-1:0]   r_count;
   logic [c_KW-1:0]   w_count_nxt;
   logic [c_KW:0]     w_occ_next;
   logic [CW-1:0]     r_stall_cnt;

   logic [1:0] w_fwdA_E;
   logic [1:0] w_fwdB_E;
   logic [1:0] w_fwdA_D;
   logic [1:0] w_fwdB_D;

   logic w_loadstall;
   logic w_branch_stall;
   logic w_raw_stall;
   logic w_waw_stall;
   logic w_full_stall;
   logic w_stall;

   // Priority select: producer A beats producer B; x0 never forwards.
   function automatic logic [1:0] fwd_sel(
      input logic [AW-1:0] src,
      input logic          wa,
      input logic [AW-1:0] ra,
      input logic          wb,
      input logic [AW-1:0] rb
   );
      if (src == '0)
         return 2'b00;
      if (wa && (ra == src))
         return 2'b10;
      if (wb && (rb == src))
         return 2'b01;
      return 2'b00;
   endfunction

   // A register completing this cycle is written on the falling edge, so it
   // no longer blocks the reader.
   function automatic logic sb_hit(
      input logic [c_NREG-1:0] busy,
      input logic [AW-1:0]     r,
      input logic              done,
      input logic [AW-1:0]     done_rd
   );
      return busy[r] & ~(done & (done_rd == r));
   endfunction

   // ------------------------------------------------------------------
   // Forwarding
   // ------------------------------------------------------------------
   always_comb begin
      w_fwdA_E = fwd_sel(rs1_E, regwrite_M, rd_M, regwrite_W, rd_W);
      w_fwdB_E = fwd_sel(rs2_E, regwrite_M, rd_M, regwrite_W, rd_W);
      w_fwdA_D = fwd_sel(rs1_D, regwrite_E, rd_E, regwrite_M, rd_M);
      w_fwdB_D = fwd_sel(rs2_D, regwrite_E, rd_E, regwrite_M, rd_M);
   end

   // ------------------------------------------------------------------
   // Stall terms
   // ------------------------------------------------------------------
   assign w_occ_next = {1'b0, r_count} + {{c_KW{1'b0}}, mc_issue_E};

   always_comb begin
      w_loadstall    = memtoreg_E & (rd_E != '0) &
                       ((rd_E == rs1_D) | (rd_E == rs2_D));
      w_branch_stall = branch_D & memtoreg_M & (rd_M != '0) &
                       ((rd_M == rs1_D) | (rd_M == rs2_D));
      w_raw_stall    = sb_hit(r_busy, rs1_D, mc_done, mc_rd) |
                       sb_hit(r_busy, rs2_D, mc_done, mc_rd);
      w_waw_stall    = regwrite_D & sb_hit(r_busy, rd_D, mc_done, mc_rd);
      // Completion is deliberately not credited here.
      w_full_stall   = mc_op_D & (w_occ_next >= c_DEPTH_W);
      w_stall        = w_loadstall | w_branch_stall | w_raw_stall |
                       w_waw_stall | w_full_stall;
   end

   assign stall_PC     = rst_n & w_stall;
   assign stall_F_to_D = rst_n & w_stall;
   assign flush_D_to_E = rst_n & w_stall;

   assign forwardA_E = rst_n ? w_fwdA_E : 2'b00;
   assign forwardB_E = rst_n ? w_fwdB_E : 2'b00;
   assign forwardA_D = rst_n ? w_fwdA_D : 2'b00;
   assign forwardB_D = rst_n ? w_fwdB_D : 2'b00;

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < c_NREG; gi++) begin : g_dec
         if (gi == 0) begin : g_r0
            assign w_busy_set[gi] = 1'b0;
            assign w_busy_clr[gi] = 1'b0;
         end else begin : g_rn
            assign w_busy_set[gi] = mc_issue_E & (rd_E == AW'(gi));
            assign w_busy_clr[gi] = mc_done & (mc_rd == AW'(gi));
         end
      end
   endgenerate

   // Set is applied after clear so a same-register collision stays busy.
   assign w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;

   always_comb begin
      w_count_nxt = r_count;
      unique case ({mc_issue_E, mc_done})
         2'b10: if (r_count != c_DEPTH) w_count_nxt = r_count + 1'b1;
         2'b01: if (r_count != '0)      w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign mc_busy = (r_count != '0);
   assign mc_full = (r_count == c_DEPTH);

   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(mc_issue_E && !mc_done && (r_count == c_DEPTH)));
         assert (!(mc_done && !mc_issue_E && (r_count == '0)));
      end
   end

   // ------------------------------------------------------------------
   // Stall-cycle counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (stat_clr)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_sb.md
# hazard_sb

Parametrised hazard and scoreboard unit for the five-stage pipeline. It keeps the existing forwarding-select and load/branch stall behaviour, and adds three things:
- a per-register busy scoreboard for a multi-cycle (MUL/DIV) unit with up to `MC_DEPTH` outstanding operations;
- RAW and WAW stalls against that scoreboard, plus a structural stall when the multi-cycle unit is full;
- a saturating stall-cycle performance counter.

It sits beside the datapath and drives the PC, F/D and D/E pipeline-register controls.

## Interface
Parameters:
- `AW`, 5, register address width; register file has 2^AW entries; register 0 is hardwired zero.
- `MC_DEPTH`, 2, maximum outstanding multi-cycle operations (1..7).
- `CW`, 16, stall counter width.

Ports:
- `clk` in 1 — clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `rs1_D`, `rs2_D`, `rd_D` in AW — D-stage source and destination registers.
- `regwrite_D` in 1 — D-stage instruction writes `rd_D`.
- `mc_op_D` in 1 — D-stage instruction is a multi-cycle operation.
- `branch_D` in 1 — D-stage instruction is a branch.
- `rs1_E`, `rs2_E`, `rd_E` in AW — E-stage registers.
- `regwrite_E`, `memtoreg_E` in 1 — E-stage control.
- `mc_issue_E` in 1 — E-stage multi-cycle op is handed to the MC unit this cycle.
- `rd_M`, `rd_W` in AW — M- and W-stage destination registers.
- `regwrite_M`, `memtoreg_M`, `regwrite_W` in 1 — M/W-stage control.
- `mc_done` in 1, `mc_rd` in AW — MC unit writes `mc_rd` this cycle via its own register-file port.
- `stat_clr` in 1 — synchronous clear of `stall_cnt`.
- `forwardA_E`, `forwardB_E` out 2 — ALU operand select: 10 = M, 01 = W, 00 = register file.
- `forwardA_D`, `forwardB_D` out 2 — branch operand select: 10 = E, 01 = M, 00 = register file.
- `stall_PC`, `stall_F_to_D` out 1 — hold the PC / F-D register.
- `flush_D_to_E` out 1 — insert a bubble into the D/E register.
- `mc_busy` out 1 — at least one multi-cycle operation is outstanding.
- `mc_full` out 1 — outstanding count equals `MC_DEPTH`.
- `stall_cnt` out CW — saturating count of stalled cycles.

## Operation
Forwarding (combinational):
- Forwarding never applies to register 0.
- E-stage priority is M over W.
- D-stage priority is E over M.
- Each source match requires the matching `regwrite`.

Stall terms (combinational; all registers compared are nonzero):
- `loadstall` = `memtoreg_E` & (`rd_E` == `rs1_D` | `rd_E` == `rs2_D`).
- `branch_stall` = `branch_D` & `memtoreg_M` & (`rd_M` matches `rs1_D` or `rs2_D`). A load in E feeding a branch therefore stalls 2 cycles: `loadstall`, then `branch_stall`.
- `sb_hit(r)` = `busy[r]` & ~(`mc_done` & `mc_rd` == r). A completing write is bypassed because the register file writes on the falling edge.
- `raw_stall` = `sb_hit(rs1_D)` | `sb_hit(rs2_D)`.
- `waw_stall` = `regwrite_D` & `sb_hit(rd_D)`.
- `full_stall` = `mc_op_D` & (`count` + `mc_issue_E` ≥ `MC_DEPTH`). `mc_done` is ignored here (conservative).
- `stall` = OR of all five terms; `stall_PC` = `stall_F_to_D` = `flush_D_to_E` = `stall`.

Scoreboard (registered):
- `busy[2^AW]` bits and an occupancy `count` (width ceil(log2(MC_DEPTH+1))).
- On `mc_issue_E` with `rd_E` ≠ 0: set `busy[rd_E]`.
- On `mc_done`: clear `busy[mc_rd]`.
- Set and clear of the same register in one cycle: set wins. Set and clear of different registers: both apply.
- `busy[0]` is always 0.
- `count`: +1 on `mc_issue_E`, −1 on `mc_done`, unchanged when both occur.
- Issue at `count` = `MC_DEPTH`, or done at `count` = 0, is a protocol error: `count` saturates and a simulation assertion fires.
- `mc_busy` = (`count` ≠ 0); `mc_full` = (`count` == `MC_DEPTH`). Both are decoded from registers only.

Performance counter:
- `stall_cnt` increments when `stall` = 1 and saturates at all-ones.
- `stat_clr` has priority: the counter loads 0 that cycle and does not count it.

## Timing
- Forwarding selects and stall/flush outputs are combinational, zero latency. They are masked to 0 while `rst_n` = 0.
- A scoreboard set is visible to D-stage checks from the cycle after `mc_issue_E`.
- A clear is visible in the same cycle as `mc_done` (bypass) and registered from the next cycle.
- Reset values:
  - `busy` = 0, `count` = 0, `stall_cnt` = 0.
  - `mc_busy` = 0, `mc_full` = 0.
  - All `forward*` = 00; all stall/flush outputs = 0.
- Reset asserted mid-operation: all state clears immediately. In-flight MC results after reset are the MC unit's responsibility; the scoreboard does not track them.

## Test plan
- Forwarding: `rs1_E` = 3, `rd_M` = 3, `regwrite_M`, and `rd_W` = 3, `regwrite_W` → `forwardA_E` = 10. With `rs1_E` = 0 and the same producers → 00.
- Load→branch: load `rd` = 5 in E, then `beq x5` in D → stall for exactly 2 cycles (`loadstall`, then `branch_stall`), with `flush_D_to_E` on both; `stall_cnt` += 2.
- RAW on scoreboard: `mc_issue_E` with `rd_E` = 7; next cycles D reads `x7` → stall every cycle. Pulse `mc_done` with `mc_rd` = 7 → stall drops in that same cycle, and `busy[7]` = 0 on the next edge.
- WAW/structural, `MC_DEPTH` = 2: two issues (`rd` 8, 9) → `mc_full` = 1. `mc_op_D` stalls; `regwrite_D` with `rd_D` = 9 stalls. Simultaneous `mc_done` (`rd` 8) and issue (`rd` 10) → `count` stays 2, `busy` = {9,10}.
- Reset/counters: drive stalls for 3 cycles, then assert `rst_n` low asynchronously mid-cycle → all outputs 0 immediately. Release → `stall_cnt` = 0. With `CW` = 2, 5 stall cycles → `stall_cnt` = 3; `stat_clr` concurrent with a stall → 0.
